regfile_port_arbiter: RTL and testbench
=======================================

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of execution sub-controllers sharing the register file (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, 64, grant watchdog limit in cycles (used only when REGFILE_ARB_TIMEOUT_EN is defined).
REQ-003 Clock clk and reset rst, synchronous, active-high, SHALL be the first two ports: clk  in  1  clock; rst  in  1  reset.
REQ-004 req  in  NREQ  per-requester access request, level.
REQ-005 rel  in  NREQ  per-requester release strobe, one cycle.
REQ-006 req_rs1, req_rs2, req_rd  in  NREQ*5 each  per-requester read/write addresses, packed by requester index.
REQ-007 req_wdata  in  NREQ*32  per-requester write data; req_we  in  NREQ  per-requester write enable.
REQ-008 gnt  out  NREQ  one-hot registered grant; busy  out  1  any grant held.
REQ-009 rf_rs1, rf_rs2, rf_rd  out  5 each; rf_wdata  out  32; rf_we  out  1  drive the single register file.
REQ-010 rf_rdata1, rf_rdata2  in  32  register file read data; rd_data1, rd_data2  out  32  read data broadcast to all requesters.
REQ-011 timeout_err  out  1  one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have two states: IDLE and GRANTED.
REQ-013 In IDLE with req != 0, the block SHALL select the first set req bit at or after rr_ptr (rotating priority), register gnt one-hot next cycle, and enter GRANTED.
REQ-014 Arbitration latency SHALL be exactly 1 cycle from req sampled in IDLE to gnt high.
REQ-015 req SHALL be sampled only in IDLE; requests arriving during GRANTED wait.
REQ-016 In GRANTED, rf_rs1/rf_rs2/rf_rd/rf_wdata SHALL combinationally mux the owner's fields, and rf_we SHALL equal the owner's req_we.
REQ-017 With no grant, rf_we SHALL be 0 and rf address/data outputs SHALL be 0.
REQ-018 rd_data1/rd_data2 SHALL pass rf_rdata1/rf_rdata2 unmodified at all times.
REQ-019 rel on the owner's index in GRANTED SHALL clear gnt next cycle, set rr_ptr to (owner+1) mod NREQ, and return to IDLE.
REQ-020 rel on a non-owner index, or any rel in IDLE, SHALL be ignored.
REQ-021 The owner deasserting req without rel SHALL NOT release the grant.
REQ-022 At least one IDLE cycle SHALL separate consecutive grants, so gnt is never high on two indices in any cycle.
REQ-023 busy SHALL equal |gnt.

Reset
REQ-024 On rst: gnt=0, busy=0, rr_ptr=0, state=IDLE, timeout counter=0, timeout_err=0; rf_we is 0 from the following cycle.
REQ-025 rst asserted mid-grant SHALL abort the grant with no release handshake; rst takes priority over rel and req.

Configuration
REQ-026 Macro REGFILE_ARB_TIMEOUT_EN defined: a counter SHALL clear on grant and increment each GRANTED cycle. When it reaches TIMEOUT_CYCLES-1 without rel, the block SHALL force release exactly as in REQ-019 and pulse timeout_err for one cycle.
REQ-027 Macro undefined: no counter is built, timeout_err is tied 0, and a grant is held until rel.

Structure
REQ-028 Package regfile_arb_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, default NREQ, and the FSM state enum.
REQ-029 Sub-module rr_priority_picker (combinational rotating-priority encoder: req, rr_ptr -> one-hot pick, valid) SHALL be instantiated once.

Verification
REQ-030 Single request: NREQ=4, req=0010 in IDLE -> gnt=0010 and busy=1 one cycle later; owner req_rs1=3 appears on rf_rs1; rel[1] -> gnt=0 next cycle, rr_ptr=2.
REQ-031 Fairness: req=1111 held, each owner releases after 2 cycles -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-032 Write gating: owner 2 drives req_we=1, req_rd=7, wdata=0xDEADBEEF; non-owner 0 drives we=1 -> rf_we=1 with rd=7 and owner data only; after release rf_we=0.
REQ-033 Foreign release: owner 1 granted, rel=0001 -> gnt stays 0010; owner drops req without rel -> gnt stays 0010.
REQ-034 Reset mid-grant: rst during GRANTED -> gnt=0, busy=0, rf_we=0 next cycle; req=1000 after reset -> grant goes to index 3 (rr_ptr=0 scan).
REQ-035 Timeout (macro defined, TIMEOUT_CYCLES=8): owner never releases -> gnt drops after 8 GRANTED cycles, timeout_err=1 for one cycle, next grant goes to the following index.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared widths, default requester count and FSM state type for the
// register-file port arbiter.
package regfile_arb_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int DATA_W       = 32;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority encoder: one-hot pick of the first set
// req bit at or after rr_ptr, wrapping modulo NREQ.
module rr_priority_picker #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  pick,
  output logic             valid
);
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      // rr_ptr < NREQ, so one conditional subtract is enough to wrap
      sum = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (sum >= (PTR_W + 1)'(NREQ)) sum = sum - (PTR_W + 1)'(NREQ);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = |req;
endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates one register-file port among NREQ sub-controllers with
// rotating priority. Define REGFILE_ARB_TIMEOUT_EN to build the grant watchdog.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ           = NREQ_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            rel,
  input  logic [NREQ*REG_ADDR_W-1:0] req_rs1,
  input  logic [NREQ*REG_ADDR_W-1:0] req_rs2,
  input  logic [NREQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NREQ*DATA_W-1:0]     req_wdata,
  input  logic [NREQ-1:0]            req_we,
  output logic [NREQ-1:0]            gnt,
  output logic                       busy,
  output logic [REG_ADDR_W-1:0]      rf_rs1,
  output logic [REG_ADDR_W-1:0]      rf_rs2,
  output logic [REG_ADDR_W-1:0]      rf_rd,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       rf_we,
  input  logic [DATA_W-1:0]          rf_rdata1,
  input  logic [DATA_W-1:0]          rf_rdata2,
  output logic [DATA_W-1:0]          rd_data1,
  output logic [DATA_W-1:0]          rd_data2,
  output logic                       timeout_err,
  output arb_state_t                 dbg_state,
  output logic [$clog2(NREQ)-1:0]    dbg_rr_ptr
);
  localparam int PTR_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("regfile_port_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  // Handshake: req is a level sampled only in IDLE; a grant is held until a
  // one-cycle rel on the owner's index (or watchdog expiry), after which the
  // arbiter spends one IDLE cycle before granting again.
  arb_state_t       state;
  logic [NREQ-1:0]  pick;
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic             tmo_hit;
  logic             release_now;

  logic [REG_ADDR_W-1:0] rs1_a [NREQ];
  logic [REG_ADDR_W-1:0] rs2_a [NREQ];
  logic [REG_ADDR_W-1:0] rd_a  [NREQ];
  logic [DATA_W-1:0]     wd_a  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rs1_a[g] = req_rs1[g*REG_ADDR_W +: REG_ADDR_W];
    assign rs2_a[g] = req_rs2[g*REG_ADDR_W +: REG_ADDR_W];
    assign rd_a[g]  = req_rd[g*REG_ADDR_W +: REG_ADDR_W];
    assign wd_a[g]  = req_wdata[g*DATA_W +: DATA_W];
  end

  rr_priority_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  assign next_ptr    = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign release_now = rel[owner] || tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= pick;
            owner <= pick_idx;
            state <= GRANTED;
          end
        end
        GRANTED: begin
          if (release_now) begin
            gnt    <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef REGFILE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_err_q;

  // Counter reads 0 in the first GRANTED cycle, so the grant lasts exactly
  // TIMEOUT_CYCLES cycles when the owner never releases.
  assign tmo_hit = (state == GRANTED) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_hit && !rel[owner];
      if (state == GRANTED && !release_now) tmo_cnt <= tmo_cnt + 1'b1;
      else                                  tmo_cnt <= '0;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    rf_rs1   = '0;
    rf_rs2   = '0;
    rf_rd    = '0;
    rf_wdata = '0;
    rf_we    = 1'b0;
    if (state == GRANTED) begin
      rf_rs1   = rs1_a[owner];
      rf_rs2   = rs2_a[owner];
      rf_rd    = rd_a[owner];
      rf_wdata = wd_a[owner];
      rf_we    = req_we[owner];
    end
  end

  assign busy       = |gnt;
  assign rd_data1   = rf_rdata1;
  assign rd_data2   = rf_rdata2;
  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter (NREQ=4, TIMEOUT_CYCLES=8); the
// watchdog steps apply when REGFILE_ARB_TIMEOUT_EN is defined.
module tb_regfile_port_arbiter;
  import regfile_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = REG_ADDR_W;
  localparam int DW = DATA_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    rel = '0;
  logic [N*AW-1:0] req_rs1 = '0;
  logic [N*AW-1:0] req_rs2 = '0;
  logic [N*AW-1:0] req_rd = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_we = '0;
  logic [N-1:0]    gnt;
  logic            busy;
  logic [AW-1:0]   rf_rs1, rf_rs2, rf_rd;
  logic [DW-1:0]   rf_wdata;
  logic            rf_we;
  logic [DW-1:0]   rf_rdata1 = '0;
  logic [DW-1:0]   rf_rdata2 = '0;
  logic [DW-1:0]   rd_data1, rd_data2;
  logic            timeout_err;
  arb_state_t      dbg_state;
  logic [1:0]      dbg_rr_ptr;

  int total = 0;
  int bad   = 0;

  regfile_port_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .rel         (rel),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_rd      (req_rd),
    .req_wdata   (req_wdata),
    .req_we      (req_we),
    .gnt         (gnt),
    .busy        (busy),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .rf_we       (rf_we),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state),
    .dbg_rr_ptr  (dbg_rr_ptr)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: observed=no finish expected=finish");
    $fatal(1, "simulation time limit");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [N-1:0] exp);
    chk({tag, ".gnt"}, 64'(gnt), 64'(exp));
    chk({tag, ".busy"}, 64'(busy), 64'(exp != '0));
  endtask

  task automatic chk_rd_pass(input string tag);
    rf_rdata1 = $urandom;
    rf_rdata2 = $urandom;
    #1;
    chk({tag, ".rd1"}, 64'(rd_data1), 64'(rf_rdata1));
    chk({tag, ".rd2"}, 64'(rd_data2), 64'(rf_rdata2));
  endtask

  initial begin
    // reset state
    step();
    step();
    rst = 1'b0;
    chk_gnt("reset", '0);
    chk("reset.rf_we", 64'(rf_we), 64'd0);
    chk("reset.tmo", 64'(timeout_err), 64'd0);
    chk("reset.state", 64'(dbg_state), 64'(IDLE));
    chk("reset.rr", 64'(dbg_rr_ptr), 64'd0);
    chk_rd_pass("reset");

    // single request on index 1
    for (int i = 0; i < N; i++) begin
      req_rs1[i*AW +: AW] = AW'(20 + i);
      req_rs2[i*AW +: AW] = AW'(10 + i);
    end
    req_rs1[1*AW +: AW] = 5'd3;
    req = 4'b0010;
    #1;
    chk_gnt("single.latency", '0);
    step();
    chk_gnt("single.grant", 4'b0010);
    chk("single.rs1", 64'(rf_rs1), 64'd3);
    chk("single.rs2", 64'(rf_rs2), 64'd11);
    chk("single.state", 64'(dbg_state), 64'(GRANTED));
    chk_rd_pass("single");
    rel = 4'b0010;
    req = '0;
    step();
    rel = '0;
    chk_gnt("single.release", '0);
    chk("single.rr", 64'(dbg_rr_ptr), 64'd2);
    chk("single.rs1_idle", 64'(rf_rs1), 64'd0);

    // fairness from rr_ptr=0 with all requests held
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("fair.rr0", 64'(dbg_rr_ptr), 64'd0);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      chk_gnt($sformatf("fair%0d.grant", g), 4'(1 << (g % 4)));
      step();
      chk_gnt($sformatf("fair%0d.hold", g), 4'(1 << (g % 4)));
      rel = 4'(1 << (g % 4));
      step();
      rel = '0;
      chk_gnt($sformatf("fair%0d.gap", g), '0);
    end
    req = '0;
    chk("fair.rr_end", 64'(dbg_rr_ptr), 64'd1);

    // write gating: owner 2 writes, non-owner 0 also asserts we
    req_rd[2*AW +: AW]    = 5'd7;
    req_rd[0*AW +: AW]    = 5'd11;
    req_wdata[2*DW +: DW] = 32'hDEADBEEF;
    req_wdata[0*DW +: DW] = 32'h12345678;
    req_we = 4'b0101;
    req    = 4'b0100;
    #1;
    chk("wr.idle_we", 64'(rf_we), 64'd0);
    step();
    chk_gnt("wr.grant", 4'b0100);
    chk("wr.we", 64'(rf_we), 64'd1);
    chk("wr.rd", 64'(rf_rd), 64'd7);
    chk("wr.wdata", 64'(rf_wdata), 64'hDEADBEEF);
    rel = 4'b0100;
    req = '0;
    step();
    rel    = '0;
    req_we = '0;
    chk("wr.we_after", 64'(rf_we), 64'd0);
    chk("wr.wdata_after", 64'(rf_wdata), 64'd0);
    chk("wr.rr", 64'(dbg_rr_ptr), 64'd3);

    // foreign release and owner dropping req
    req = 4'b0010;
    step();
    chk_gnt("foreign.grant", 4'b0010);
    rel = 4'b0001;
    step();
    rel = '0;
    chk_gnt("foreign.rel", 4'b0010);
    req = 4'b1000;
    step();
    chk_gnt("foreign.drop1", 4'b0010);
    step();
    chk_gnt("foreign.drop2", 4'b0010);
    rel = 4'b0010;
    step();
    rel = '0;
    chk_gnt("foreign.release", '0);
    chk("foreign.rr", 64'(dbg_rr_ptr), 64'd2);
    req_we = 4'b1000;
    step();
    chk_gnt("foreign.next", 4'b1000);
    chk("foreign.we3", 64'(rf_we), 64'd1);

    // reset mid-grant
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_gnt("rst_mid", '0);
    chk("rst_mid.we", 64'(rf_we), 64'd0);
    chk("rst_mid.rr", 64'(dbg_rr_ptr), 64'd0);
    chk("rst_mid.state", 64'(dbg_state), 64'(IDLE));
    step();
    chk_gnt("rst_mid.regrant", 4'b1000);
    req_we = '0;

    // owner 3 never releases
    req = 4'b1111;
`ifdef REGFILE_ARB_TIMEOUT_EN
    for (int k = 2; k <= 8; k++) begin
      step();
      chk_gnt($sformatf("tmo.hold%0d", k), 4'b1000);
      chk($sformatf("tmo.err%0d", k), 64'(timeout_err), 64'd0);
    end
    step();
    chk_gnt("tmo.drop", '0);
    chk("tmo.pulse", 64'(timeout_err), 64'd1);
    chk("tmo.rr", 64'(dbg_rr_ptr), 64'd0);
    step();
    chk_gnt("tmo.next", 4'b0001);
    chk("tmo.pulse_end", 64'(timeout_err), 64'd0);
`else
    for (int k = 0; k < 12; k++) begin
      step();
      chk_gnt($sformatf("hold%0d", k), 4'b1000);
      chk($sformatf("hold%0d.err", k), 64'(timeout_err), 64'd0);
    end
    rel = 4'b1000;
    step();
    rel = '0;
    chk_gnt("hold.release", '0);
    chk("hold.rr", 64'(dbg_rr_ptr), 64'd0);
    step();
    chk_gnt("hold.next", 4'b0001);
`endif
    rel = 4'b0001;
    req = '0;
    step();
    rel = '0;
    chk_gnt("final", '0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
